fetch_queue: RTL and testbench

Instruction-fetch stage that sits directly downstream of the PC register and consumes the `pc` value it produces. It issues instruction-memory reads at `pc`, keeps at most one request in flight, and buffers returned words with their PC in a small FIFO for decode. It drives the PC register's advance enable, and it discards in-flight or buffered fetches when a taken branch flushes the front end.

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-memory read bus between fetch_queue and imem
interface fetch_queue_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              imemReq;
  logic [ADDR_W-1:0] imemAddr;
  logic              imemGnt;
  logic              imemRvalid;
  logic [DATA_W-1:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemGnt,
    input  imemRvalid,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemGnt,
    output imemRvalid,
    output imemRdata
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - single-outstanding instruction fetch with PC-tagged FIFO and flush
// Optional same-cycle response bypass to decode: FETCH_BYPASS_EN.
module fetch_queue #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pcEn,
  input  logic              flush,
  fetch_queue_if.master     imem,
  output logic              instrValid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instrPc,
  input  logic              decReady
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic          resp_in_wait;
  logic [CW:0]   cnt_lookahead;
  logic          grant;
  logic          push;
  logic          pop;
  logic          fifo_valid;

  // Occupancy credit counts the response landing now, but never a same-cycle pop.
  assign resp_in_wait  = (state_q == WAIT) && imem.imemRvalid;
  assign cnt_lookahead = {1'b0, cnt_q} + {{CW{1'b0}}, resp_in_wait};
  assign imem.imemReq  = rst && !flush && ((state_q == IDLE) || resp_in_wait)
                         && (cnt_lookahead < (CW+1)'(DEPTH));
  assign imem.imemAddr = pc;
  assign grant         = imem.imemReq && imem.imemGnt;
  assign pcEn          = rst && (grant || flush);
  assign fifo_valid    = (cnt_q != '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = resp_in_wait && !flush && !fifo_valid;
  assign instrValid = fifo_valid || bypass;
  assign instr      = bypass ? imem.imemRdata : data_q[rd_ptr_q];
  assign instrPc    = bypass ? pend_pc_q : pc_q[rd_ptr_q];
  assign push       = resp_in_wait && !flush && !(bypass && decReady);
  assign pop        = fifo_valid && decReady;
`else
  assign instrValid = fifo_valid;
  assign instr      = data_q[rd_ptr_q];
  assign instrPc    = pc_q[rd_ptr_q];
  assign push       = resp_in_wait && !flush;
  assign pop        = fifo_valid && decReady;
`endif

  always_comb begin
    state_d   = state_q;
    pend_pc_d = grant ? pc : pend_pc_q;
    case (state_q)
      IDLE: if (grant) state_d = WAIT;
      WAIT: begin
        if (flush)                  state_d = imem.imemRvalid ? IDLE : DROP;
        else if (imem.imemRvalid)   state_d = grant ? WAIT : IDLE;
      end
      DROP: if (imem.imemRvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= imem.imemRdata;
      pc_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with PC register and memory models
module tb_fetch_queue;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic              pcEn;
  logic              flush;
  logic [ADDR_W-1:0] target;
  logic              gnt;
  logic              man_rv;
  logic [DATA_W-1:0] man_data;
  logic              auto_mode;
  logic              auto_rv;
  logic [ADDR_W-1:0] auto_addr;
  logic              decReady;
  logic              instrValid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instrPc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem_if ();

  assign imem_if.imemGnt    = gnt;
  assign imem_if.imemRvalid = auto_mode ? auto_rv : man_rv;
  assign imem_if.imemRdata  = auto_mode ? {8'hC0, auto_addr} : man_data;

  fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pcEn       (pcEn),
    .flush      (flush),
    .imem       (imem_if.master),
    .instrValid (instrValid),
    .instr      (instr),
    .instrPc    (instrPc),
    .decReady   (decReady)
  );

  // PC register and zero-wait memory (response the cycle after each grant)
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= '0;
      auto_rv   <= 1'b0;
      auto_addr <= '0;
    end else begin
      if (pcEn) pc <= flush ? target : pc + 24'd4;
      auto_rv   <= imem_if.imemReq && imem_if.imemGnt;
      auto_addr <= imem_if.imemAddr;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic hold_reset(input logic am);
    rst       = 1'b0;
    flush     = 1'b0;
    target    = '0;
    auto_mode = am;
    gnt       = am;
    man_rv    = 1'b0;
    man_data  = '0;
    decReady  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // reset state
    hold_reset(1'b1);
    #1;
    check("rst_req",    imem_if.imemReq, 0);
    check("rst_pcen",   pcEn, 0);
    check("rst_valid",  instrValid, 0);
    check("rst_instr",  instr, 0);
    check("rst_ipc",    instrPc, 0);

    // zero-wait streaming, decode always ready
    decReady = 1'b1;
    rst = 1'b1; #1;
    check("s0_req",  imem_if.imemReq, 1);
    check("s0_addr", imem_if.imemAddr, 24'h000000);
    check("s0_pcen", pcEn, 1);
    @(negedge clk); #1;
    check("s1_addr",  imem_if.imemAddr, 24'h000004);
    check("s1_req",   imem_if.imemReq, 1);
    check("s1_valid", instrValid, 0);
    @(negedge clk); #1;
    check("s2_req",   imem_if.imemReq, 0);
    check("s2_valid", instrValid, 1);
    check("s2_ipc",   instrPc, 24'h000000);
    check("s2_instr", instr, 32'hC0000000);
    @(negedge clk); #1;
    check("s3_req",   imem_if.imemReq, 1);
    check("s3_addr",  imem_if.imemAddr, 24'h000008);
    check("s3_ipc",   instrPc, 24'h000004);
    @(negedge clk); #1;
    check("s4_valid", instrValid, 0);
    check("s4_addr",  imem_if.imemAddr, 24'h00000C);

    // decode stall fills FIFO, then drains in order
    hold_reset(1'b1);
    rst = 1'b1; #1;
    repeat (3) @(negedge clk);
    #1;
    check("st3_req",  imem_if.imemReq, 0);
    check("st3_ipc",  instrPc, 24'h000000);
    @(negedge clk); #1;
    check("st4_req",  imem_if.imemReq, 0);
    check("st4_valid", instrValid, 1);
    decReady = 1'b1; #1;
    @(negedge clk); #1;
    check("st5_ipc",  instrPc, 24'h000004);
    check("st5_req",  imem_if.imemReq, 1);
    check("st5_addr", imem_if.imemAddr, 24'h000008);

    // flush while a request is outstanding
    hold_reset(1'b0);
    flush = 1'b1; target = 24'h000010;
    rst = 1'b1; #1;
    check("fl0_req",  imem_if.imemReq, 0);
    check("fl0_pcen", pcEn, 1);
    @(negedge clk); flush = 1'b0; gnt = 1'b1; #1;
    check("fl1_addr", imem_if.imemAddr, 24'h000010);
    check("fl1_req",  imem_if.imemReq, 1);
    @(negedge clk); gnt = 1'b0; flush = 1'b1; target = 24'h000100; #1;
    check("fl2_pcen", pcEn, 1);
    check("fl2_req",  imem_if.imemReq, 0);
    @(negedge clk); flush = 1'b0; #1;
    check("fl3_req",  imem_if.imemReq, 0);
    @(negedge clk); man_rv = 1'b1; man_data = 32'h11111111; #1;
    check("fl4_req",  imem_if.imemReq, 0);
    @(negedge clk); man_rv = 1'b0; gnt = 1'b1; #1;
    check("fl5_req",  imem_if.imemReq, 1);
    check("fl5_addr", imem_if.imemAddr, 24'h000100);
    check("fl5_valid", instrValid, 0);
    @(negedge clk); man_rv = 1'b1; man_data = 32'h22222222; gnt = 1'b0; #1;
    @(negedge clk); man_rv = 1'b0; #1;
    check("fl7_valid", instrValid, 1);
    check("fl7_ipc",   instrPc, 24'h000100);
    check("fl7_instr", instr, 32'h22222222);

    // flush coincident with response and pop
    hold_reset(1'b0);
    gnt = 1'b1;
    rst = 1'b1; #1;
    @(negedge clk); man_rv = 1'b1; man_data = 32'hAAAA0000; gnt = 1'b0; #1;
    @(negedge clk); man_rv = 1'b0; gnt = 1'b1; #1;
    check("fc2_addr", imem_if.imemAddr, 24'h000004);
    @(negedge clk);
    man_rv = 1'b1; man_data = 32'hBBBB0000; gnt = 1'b0;
    decReady = 1'b1; flush = 1'b1; target = 24'h000200; #1;
    check("fc3_pcen",  pcEn, 1);
    check("fc3_req",   imem_if.imemReq, 0);
    check("fc3_valid", instrValid, 1);
    @(negedge clk); man_rv = 1'b0; flush = 1'b0; #1;
    check("fc4_valid", instrValid, 0);
    check("fc4_req",   imem_if.imemReq, 1);
    check("fc4_addr",  imem_if.imemAddr, 24'h000200);

    // reset asserted mid-operation
    hold_reset(1'b0);
    gnt = 1'b1;
    rst = 1'b1; #1;
    @(negedge clk); man_rv = 1'b1; man_data = 32'h12345678; #1;
    @(negedge clk); man_rv = 1'b0; gnt = 1'b0; #1;
    check("mr_pre_valid", instrValid, 1);
    rst = 1'b0; #1;
    check("mr_req",   imem_if.imemReq, 0);
    check("mr_pcen",  pcEn, 0);
    check("mr_valid", instrValid, 0);
    check("mr_instr", instr, 0);
    check("mr_ipc",   instrPc, 0);
    @(negedge clk); rst = 1'b1; man_rv = 1'b1; man_data = 32'h55555555; #1;
    check("mr_stale0", instrValid, 0);
    @(negedge clk); man_rv = 1'b0; #1;
    check("mr_stale1", instrValid, 0);

    // response latency into decode
    hold_reset(1'b0);
    gnt = 1'b1;
    rst = 1'b1; #1;
    @(negedge clk); man_rv = 1'b1; man_data = 32'hDEADBEEF; gnt = 1'b0; #1;
`ifdef FETCH_BYPASS_EN
    check("bp_valid", instrValid, 1);
    check("bp_instr", instr, 32'hDEADBEEF);
`else
    check("bp_valid", instrValid, 0);
`endif
    @(negedge clk); man_rv = 1'b0; #1;
    check("bp_valid1", instrValid, 1);
    check("bp_instr1", instr, 32'hDEADBEEF);
    check("bp_ipc1",   instrPc, 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
